// File: rtl/instr_reg_ctrl.sv
// instr_reg_ctrl: sequencing controller for an external instruction register file.
// Two requesters write {opcode, op_a, op_b} entries through an arbiter; a single
// reader pops entries in order. The controller owns the write/read pointers, the
// occupancy count and a short post-reset hold on the register file (reset_n).
//
// Build option: define INSTR_CTRL_FIXED_PRIO_EN to give requester 0 fixed priority
// (no last-grant register). Default build uses round-robin between requesters.

package instr_reg_pkg;
    typedef logic [3:0]         opcode_t;
    typedef logic signed [31:0] operand_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    localparam opcode_t OP_ADD = 4'h1;
endpackage

// state | meaning
// ------+-----------------------------------------------------------------
// INIT  | register file held in reset (reset_n=0) for 2 cycles; no traffic
// RUN   | normal operation, reset_n=1; left only through reset
module instr_reg_ctrl
    import instr_reg_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  opcode_t             req0_opcode,
    input  operand_t            req0_op_a,
    input  operand_t            req0_op_b,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  opcode_t             req1_opcode,
    input  operand_t            req1_op_a,
    input  operand_t            req1_op_b,

    input  logic                rd_req,
    output logic                rd_valid,
    output instruction_t        rd_instr,

    output logic                reset_n,
    output logic                load_en,
    output opcode_t             opcode,
    output operand_t            operand_a,
    output operand_t            operand_b,
    output logic [ADDR_W-1:0]   write_pointer,
    output logic [ADDR_W-1:0]   read_pointer,
    input  instruction_t        instruction_word,

    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0]        C_INIT_LOAD = 2'd1;
    localparam logic [ADDR_W:0]   C_FULL      = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE   = ADDR_W'(1);

    state_t              r_state;
    logic [1:0]          r_init_cnt;
    logic                r_reset_n;

    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_rd_valid;
    instruction_t        r_rd_instr;

    logic                w_run;
    logic                w_full;
    logic                w_empty;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_ready0;
    logic                w_ready1;
    logic                w_wr0;
    logic                w_wr1;
    logic                w_wr;
    logic                w_pop;

    // Sequencer: down-counter holds INIT for two cycles, then RUN until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= C_INIT_LOAD;
            r_reset_n  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == 2'd0) begin
                        r_state   <= ST_RUN;
                        r_reset_n <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt - 2'd1;
                    end
                end
                ST_RUN: begin
                    r_state   <= ST_RUN;
                    r_reset_n <= 1'b1;
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_init_cnt <= C_INIT_LOAD;
                    r_reset_n  <= 1'b0;
                end
            endcase
        end
    end

    assign w_run   = (r_state == ST_RUN);
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);

`ifdef INSTR_CTRL_FIXED_PRIO_EN
    // Fixed priority: requester 0 always wins a contest.
    always_comb begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid & ~req0_valid;
    end
`else
    // 0: requester 0 was granted last, 1: requester 1 was granted last.
    logic r_last_grant;

    // Round-robin: on a contest, the requester not granted last wins.
    always_comb begin
        w_grant0 = req0_valid & (~req1_valid | r_last_grant);
        w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
    end

    // Remember which requester completed the most recent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_wr) begin
            r_last_grant <= w_wr1;
        end
    end
`endif

    // Ready depends only on state, occupancy and the grant, never on ready itself.
    always_comb begin
        w_ready0 = w_run & ~w_full & w_grant0;
        w_ready1 = w_run & ~w_full & w_grant1;
        w_wr0    = req0_valid & w_ready0;
        w_wr1    = req1_valid & w_ready1;
        w_wr     = w_wr0 | w_wr1;
        w_pop    = rd_req & ~w_empty & w_run;
    end

    // Register-file write port: winner's payload on a write, zeros otherwise.
    always_comb begin
        opcode    = '0;
        operand_a = '0;
        operand_b = '0;
        if (w_wr0) begin
            opcode    = req0_opcode;
            operand_a = req0_op_a;
            operand_b = req0_op_b;
        end else if (w_wr1) begin
            opcode    = req1_opcode;
            operand_a = req1_op_a;
            operand_b = req1_op_b;
        end
    end

    // Pointers, occupancy and the registered read data; a write landing in an
    // empty store is not forwarded, so the reader sees it a cycle later at earliest.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_instr <= '0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
                r_rd_instr <= instruction_word;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    assign req0_ready    = w_ready0;
    assign req1_ready    = w_ready1;
    assign load_en       = w_wr;
    assign write_pointer = r_wr_ptr;
    assign read_pointer  = r_rd_ptr;
    assign reset_n       = r_reset_n;
    assign rd_valid      = r_rd_valid;
    assign rd_instr      = r_rd_instr;
    assign count         = r_count;
    assign full          = w_full;
    assign empty         = w_empty;

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Directed bench for instr_reg_ctrl with a behavioural register file attached.
module tb_instr_reg_ctrl;
    import instr_reg_pkg::*;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    opcode_t           req0_opcode, req1_opcode, opcode;
    operand_t          req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    operand_t          operand_a, operand_b;
    logic              rd_req, rd_valid, reset_n, load_en, full, empty;
    instruction_t      rd_instr, instruction_word;
    logic [ADDR_W-1:0] write_pointer, read_pointer;
    logic [ADDR_W:0]   count;

    instruction_t      r_mem [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    instr_reg_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_instr(rd_instr),
        .reset_n(reset_n), .load_en(load_en), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .instruction_word(instruction_word),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // register file model
    always @(posedge clk) begin
        if (load_en) r_mem[write_pointer] <= {opcode, operand_a, operand_b};
    end
    assign instruction_word = r_mem[read_pointer];

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic instruction_t mk(input opcode_t o, input operand_t a, input operand_t b);
        return {o, a, b};
    endfunction

    initial begin
        logic g0;
        req0_valid = 1'b0; req1_valid = 1'b0; rd_req = 1'b0;
        req0_opcode = '0; req0_op_a = '0; req0_op_b = '0;
        req1_opcode = '0; req1_op_a = '0; req1_op_b = '0;

        // reset values
        repeat (3) tick;
        chk("rst_reset_n", 68'(reset_n), 68'(0));
        chk("rst_count", 68'(count), 68'(0));
        chk("rst_empty", 68'(empty), 68'(1));
        chk("rst_full", 68'(full), 68'(0));
        chk("rst_rd_valid", 68'(rd_valid), 68'(0));
        chk("rst_rd_instr", 68'(rd_instr), 68'(0));
        chk("rst_wp", 68'(write_pointer), 68'(0));
        chk("rst_rp", 68'(read_pointer), 68'(0));
        chk("rst_load_en", 68'(load_en), 68'(0));

        // INIT: requests ignored for two cycles
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rd_req = 1'b1;
        @(negedge clk);
        chk("init_ready0", 68'(req0_ready), 68'(0));
        chk("init_ready1", 68'(req1_ready), 68'(0));
        chk("init_load_en", 68'(load_en), 68'(0));
        chk("init_reset_n_c1", 68'(reset_n), 68'(0));
        tick;
        req0_valid = 1'b0; req1_valid = 1'b0; rd_req = 1'b0;
        chk("init_reset_n_c2", 68'(reset_n), 68'(0));
        chk("init_rd_valid", 68'(rd_valid), 68'(0));
        tick;
        chk("run_reset_n", 68'(reset_n), 68'(1));
        chk("run_count", 68'(count), 68'(0));
        chk("run_empty", 68'(empty), 68'(1));

        // contest for four cycles
        req0_opcode = OP_ADD; req0_op_a = 5; req0_op_b = 3;
        req1_opcode = 4'h2;   req1_op_a = 7; req1_op_b = 9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef INSTR_CTRL_FIXED_PRIO_EN
            g0 = 1'b1;
`else
            g0 = (i % 2 == 0);
`endif
            @(negedge clk);
            chk("arb_ready0", 68'(req0_ready), 68'(g0));
            chk("arb_ready1", 68'(req1_ready), 68'(!g0));
            chk("arb_wp", 68'(write_pointer), 68'(i));
            chk("arb_load_en", 68'(load_en), 68'(1));
            chk("arb_opcode", 68'(opcode), g0 ? 68'(1) : 68'(2));
            tick;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("arb_count", 68'(count), 68'(4));

        // fill to 32 entries
        req0_valid = 1'b1; req0_opcode = 4'h3;
        for (int k = 4; k < DEPTH; k++) begin
            req0_op_a = k; req0_op_b = -k;
            tick;
        end
        @(negedge clk);
        chk("full_count", 68'(count), 68'(32));
        chk("full_flag", 68'(full), 68'(1));
        chk("full_ready0", 68'(req0_ready), 68'(0));
        chk("full_load_en", 68'(load_en), 68'(0));
        chk("full_opcode", 68'(opcode), 68'(0));
        chk("full_operand_a", 68'(operand_a), 68'(0));
        rd_req = 1'b1;
        #1;
        chk("full_pop_ready0", 68'(req0_ready), 68'(0));
        chk("full_pop_load_en", 68'(load_en), 68'(0));
        tick;
        chk("pop0_count", 68'(count), 68'(31));
        chk("pop0_rd_valid", 68'(rd_valid), 68'(1));
        chk("pop0_rd_instr", 68'(rd_instr), 68'(mk(OP_ADD, 5, 3)));
        chk("pop0_rp", 68'(read_pointer), 68'(1));
        chk("pop0_wp", 68'(write_pointer), 68'(0));
        req0_valid = 1'b0; rd_req = 1'b0;
        tick;
        chk("pop0_pulse", 68'(rd_valid), 68'(0));
        chk("pop0_hold", 68'(rd_instr), 68'(mk(OP_ADD, 5, 3)));

        // drain down to three entries
        rd_req = 1'b1;
        repeat (28) tick;
        rd_req = 1'b0;
        chk("drain_count", 68'(count), 68'(3));
        chk("drain_rp", 68'(read_pointer), 68'(29));
        chk("drain_rd_instr", 68'(rd_instr), 68'(mk(4'h3, 28, -28)));

        // simultaneous write and pop at count 3
        req1_valid = 1'b1; req1_opcode = 4'h4; req1_op_a = 100; req1_op_b = -100;
        rd_req = 1'b1;
        @(negedge clk);
        chk("wp_ready1", 68'(req1_ready), 68'(1));
        chk("wp_load_en", 68'(load_en), 68'(1));
        tick;
        req1_valid = 1'b0; rd_req = 1'b0;
        chk("wp_count", 68'(count), 68'(3));
        chk("wp_wp", 68'(write_pointer), 68'(1));
        chk("wp_rp", 68'(read_pointer), 68'(30));
        chk("wp_rd_instr", 68'(rd_instr), 68'(mk(4'h3, 29, -29)));

        // grow to five, then reset mid-stream with write and pop pending
        req0_valid = 1'b1; req0_opcode = 4'h5; req0_op_a = 11; req0_op_b = 12;
        repeat (2) tick;
        chk("pre_rst_count", 68'(count), 68'(5));
        reset = 1'b1; rd_req = 1'b1;
        tick;
        chk("mrst_count", 68'(count), 68'(0));
        chk("mrst_wp", 68'(write_pointer), 68'(0));
        chk("mrst_rp", 68'(read_pointer), 68'(0));
        chk("mrst_rd_valid", 68'(rd_valid), 68'(0));
        chk("mrst_reset_n", 68'(reset_n), 68'(0));
        chk("mrst_ready0", 68'(req0_ready), 68'(0));
        chk("mrst_rd_instr", 68'(rd_instr), 68'(0));
        reset = 1'b0; req0_valid = 1'b0; rd_req = 1'b0;
        tick;
        chk("mrst_init_reset_n", 68'(reset_n), 68'(0));
        tick;
        chk("mrst_run_reset_n", 68'(reset_n), 68'(1));

        // pop while empty is ignored
        rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        chk("empty_rd_valid", 68'(rd_valid), 68'(0));
        chk("empty_rp", 68'(read_pointer), 68'(0));
        chk("empty_count", 68'(count), 68'(0));

        // 40 write/pop pairs wrap both pointers
        for (int j = 0; j < 40; j++) begin
            req0_valid = 1'b1; req0_opcode = 4'h6; req0_op_a = j; req0_op_b = j + 1;
            if (j == 0) req1_valid = 1'b1;
            @(negedge clk);
            if (j == 0) begin
                chk("post_rst_ready0", 68'(req0_ready), 68'(1));
                chk("post_rst_ready1", 68'(req1_ready), 68'(0));
            end
            tick;
            req0_valid = 1'b0; req1_valid = 1'b0;
            rd_req = 1'b1;
            tick;
            rd_req = 1'b0;
            chk("pair_rd_instr", 68'(rd_instr), 68'(mk(4'h6, j, j + 1)));
        end
        chk("wrap_wp", 68'(write_pointer), 68'(8));
        chk("wrap_rp", 68'(read_pointer), 68'(8));
        chk("wrap_empty", 68'(empty), 68'(1));

        rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        tick;
        chk("empty2_rd_valid", 68'(rd_valid), 68'(0));
        chk("empty2_hold", 68'(rd_instr), 68'(mk(4'h6, 39, 40)));
        chk("empty2_rp", 68'(read_pointer), 68'(8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
